// File: rtl/csr_reg_pkg.sv
// Shared CSR address map, mstatus field positions and write-data field masking
// for the machine-mode CSR file.
package csr_reg_pkg;

  localparam int          REG_BUS_W      = 32;
  localparam int          MEM_ADDR_BUS_W = 32;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

  // Index of each writable CSR in the per-register write-enable/data vectors
  localparam int W_MSTATUS   = 0;
  localparam int W_MIE       = 1;
  localparam int W_MTVEC     = 2;
  localparam int W_MSCRATCH  = 3;
  localparam int W_MEPC      = 4;
  localparam int W_MCAUSE    = 5;
  localparam int W_MCYCLE    = 6;
  localparam int W_MCYCLEH   = 7;
  localparam int W_MINSTRET  = 8;
  localparam int W_MINSTRETH = 9;
  localparam int NUM_WREG    = 10;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } csr_wr_t;

  function automatic logic [11:0] wreg_addr(input int idx);
    case (idx)
      W_MSTATUS:   return CSR_MSTATUS;
      W_MIE:       return CSR_MIE;
      W_MTVEC:     return CSR_MTVEC;
      W_MSCRATCH:  return CSR_MSCRATCH;
      W_MEPC:      return CSR_MEPC;
      W_MCAUSE:    return CSR_MCAUSE;
      W_MCYCLE:    return CSR_MCYCLE;
      W_MCYCLEH:   return CSR_MCYCLEH;
      W_MINSTRET:  return CSR_MINSTRET;
      default:     return CSR_MINSTRETH;
    endcase
  endfunction

  // Converts raw write data into the value the register will read back as
  function automatic logic [31:0] field_mask(input logic [11:0] addr, input logic [31:0] data);
    case (addr)
      CSR_MSTATUS:         return (data & MSTATUS_WMASK) | MSTATUS_FIXED;
      CSR_MTVEC, CSR_MEPC: return {data[31:2], 2'b00};
      default:             return data;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter split into independently writable 32-bit halves; a write to one
// half overrides only that half, the other half still takes the old-value carry.
module csr_counter64 #(
  parameter logic [63:0] STEP = 64'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        lo_we,
  input  logic [31:0] lo_wdata,
  input  logic        hi_we,
  input  logic [31:0] hi_wdata,
  output logic [63:0] count_o
);

  logic [31:0] lo_reg, hi_reg;
  logic [31:0] lo_next, hi_next;
  logic [63:0] sum;

  always_comb begin
    sum     = {hi_reg, lo_reg} + (inc_en ? STEP : 64'd0);
    lo_next = lo_we ? lo_wdata : sum[31:0];
    hi_next = hi_we ? hi_wdata : sum[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_reg <= 32'h0;
      hi_reg <= 32'h0;
    end else begin
      lo_reg <= lo_next;
      hi_reg <= hi_next;
    end
  end

  assign count_o = {hi_reg, lo_reg};

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file with ex and clint write ports and a combinational read port.
// Optional macro CSR_BYPASS_EN forwards same-cycle write data onto csr_rdata_o.
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter int          INSTRET_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        clint_we_i,
  input  logic [31:0] clint_waddr_i,
  input  logic [31:0] clint_wdata_i,
  input  logic        instret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic        global_int_en_o
);

  csr_wr_t wr_port [2];
  assign wr_port[0] = '{we: we_i,       addr: waddr_i,       data: wdata_i};
  assign wr_port[1] = '{we: clint_we_i, addr: clint_waddr_i, data: clint_wdata_i};

  logic [NUM_WREG-1:0] wr_en;
  logic [31:0]         wr_data [NUM_WREG];

  // Per-register write select; clint wins when both ports target the same CSR
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WREG; gi++) begin : g_wsel
      localparam logic [31:0] ADDR = {20'h0, wreg_addr(gi)};
      logic hit_ex, hit_clint;
      assign hit_ex      = wr_port[0].we && (wr_port[0].addr == ADDR);
      assign hit_clint   = wr_port[1].we && (wr_port[1].addr == ADDR);
      assign wr_en[gi]   = hit_ex | hit_clint;
      assign wr_data[gi] = field_mask(ADDR[11:0], hit_clint ? wr_port[1].data : wr_port[0].data);
    end
  endgenerate

  logic        mstatus_mie_reg, mstatus_mpie_reg;
  logic [31:0] mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= ZERO_WORD;
      mtvec_reg        <= field_mask(CSR_MTVEC, MTVEC_RESET);
      mscratch_reg     <= ZERO_WORD;
      mepc_reg         <= ZERO_WORD;
      mcause_reg       <= ZERO_WORD;
    end else begin
      if (wr_en[W_MSTATUS]) begin
        mstatus_mie_reg  <= wr_data[W_MSTATUS][MSTATUS_MIE];
        mstatus_mpie_reg <= wr_data[W_MSTATUS][MSTATUS_MPIE];
      end
      if (wr_en[W_MIE])      mie_reg      <= wr_data[W_MIE];
      if (wr_en[W_MTVEC])    mtvec_reg    <= wr_data[W_MTVEC];
      if (wr_en[W_MSCRATCH]) mscratch_reg <= wr_data[W_MSCRATCH];
      if (wr_en[W_MEPC])     mepc_reg     <= wr_data[W_MEPC];
      if (wr_en[W_MCAUSE])   mcause_reg   <= wr_data[W_MCAUSE];
    end
  end

  logic [63:0] cycle_cnt, instret_cnt;

  csr_counter64 #(.STEP(64'd1)) u_cycle (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (1'b1),
    .lo_we    (wr_en[W_MCYCLE]),
    .lo_wdata (wr_data[W_MCYCLE]),
    .hi_we    (wr_en[W_MCYCLEH]),
    .hi_wdata (wr_data[W_MCYCLEH]),
    .count_o  (cycle_cnt)
  );

  csr_counter64 #(.STEP(64'(INSTRET_STEP))) u_instret (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (instret_i),
    .lo_we    (wr_en[W_MINSTRET]),
    .lo_wdata (wr_data[W_MINSTRET]),
    .hi_we    (wr_en[W_MINSTRETH]),
    .hi_wdata (wr_data[W_MINSTRETH]),
    .count_o  (instret_cnt)
  );

  logic [31:0] mstatus_val;

  always_comb begin
    mstatus_val = ZERO_WORD;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_val[MSTATUS_MIE]  = mstatus_mie_reg;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie_reg;
  end

  logic [31:0] stored_rdata;

  always_comb begin
    stored_rdata = ZERO_WORD;
    if (csr_raddr_i[31:12] == 20'h0) begin
      case (csr_raddr_i[11:0])
        CSR_MSTATUS:                 stored_rdata = mstatus_val;
        CSR_MIE:                     stored_rdata = mie_reg;
        CSR_MTVEC:                   stored_rdata = mtvec_reg;
        CSR_MSCRATCH:                stored_rdata = mscratch_reg;
        CSR_MEPC:                    stored_rdata = mepc_reg;
        CSR_MCAUSE:                  stored_rdata = mcause_reg;
        CSR_MCYCLE,   CSR_CYCLE:     stored_rdata = cycle_cnt[31:0];
        CSR_MCYCLEH,  CSR_CYCLEH:    stored_rdata = cycle_cnt[63:32];
        CSR_MINSTRET, CSR_INSTRET:   stored_rdata = instret_cnt[31:0];
        CSR_MINSTRETH, CSR_INSTRETH: stored_rdata = instret_cnt[63:32];
        default:                     stored_rdata = ZERO_WORD;
      endcase
    end
  end

`ifdef CSR_BYPASS_EN
  // Only writable addresses can match, so read-only mirrors never forward
  always_comb begin
    csr_rdata_o = stored_rdata;
    for (int i = 0; i < NUM_WREG; i++) begin
      if (wr_en[i] && (csr_raddr_i == {20'h0, wreg_addr(i)})) csr_rdata_o = wr_data[i];
    end
  end
`else
  assign csr_rdata_o = stored_rdata;
`endif

  assign mtvec_o         = mtvec_reg;
  assign mepc_o          = mepc_reg;
  assign mstatus_o       = mstatus_val;
  assign global_int_en_o = mstatus_mie_reg;

endmodule

// File: tb/tb_csr_reg.sv
// Directed self-checking bench for csr_reg; stimulus changes on the falling edge
// and outputs are sampled shortly after it, well clear of the rising edge.
module tb_csr_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        we_i;
  logic [31:0] waddr_i;
  logic [31:0] wdata_i;
  logic        clint_we_i;
  logic [31:0] clint_waddr_i;
  logic [31:0] clint_wdata_i;
  logic        instret_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic [31:0] mstatus_o;
  logic        global_int_en_o;

  int compared   = 0;
  int mismatched = 0;

  csr_reg #(.MTVEC_RESET(32'h0000_0000), .INSTRET_STEP(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .csr_raddr_i     (csr_raddr_i),
    .csr_rdata_o     (csr_rdata_o),
    .we_i            (we_i),
    .waddr_i         (waddr_i),
    .wdata_i         (wdata_i),
    .clint_we_i      (clint_we_i),
    .clint_waddr_i   (clint_waddr_i),
    .clint_wdata_i   (clint_wdata_i),
    .instret_i       (instret_i),
    .mtvec_o         (mtvec_o),
    .mepc_o          (mepc_o),
    .mstatus_o       (mstatus_o),
    .global_int_en_o (global_int_en_o)
  );

  always #50 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    we_i       = 1'b0;
    clint_we_i = 1'b0;
    instret_i  = 1'b0;
  endtask

  task automatic ex_wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    $display("ex    wr addr=%h data=%h", a, d);
  endtask

  task automatic clint_wr(input logic [31:0] a, input logic [31:0] d);
    clint_we_i = 1'b1; clint_waddr_i = a; clint_wdata_i = d;
    $display("clint wr addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    csr_raddr_i = a;
    #1;
    $display("rd    addr=%h data=%h", a, csr_rdata_o);
  endtask

  task automatic test_reset();
    logic [31:0] addrs [14];
    logic [31:0] exp;
    addrs = '{32'h300, 32'h304, 32'h305, 32'h340, 32'h341, 32'h342, 32'hB00,
              32'hB80, 32'hB02, 32'hB82, 32'hC00, 32'hC80, 32'hC02, 32'hC82};
    rst = 1'b1; idle();
    tick(); tick();
    for (int i = 0; i < 14; i++) begin
      rd(addrs[i]);
      exp = (addrs[i] == 32'h300) ? 32'h0000_1800 : 32'h0;
      compared++;
      if (csr_rdata_o !== exp) begin
        mismatched++;
        $display("FAIL reset_read addr=%h: got %h expected %h", addrs[i], csr_rdata_o, exp);
      end
    end
    compared++;
    if (mtvec_o !== 32'h0) begin mismatched++; $display("FAIL reset_mtvec: got %h expected %h", mtvec_o, 32'h0); end
    compared++;
    if (mstatus_o !== 32'h1800) begin mismatched++; $display("FAIL reset_mstatus: got %h expected %h", mstatus_o, 32'h1800); end
    compared++;
    if (global_int_en_o !== 1'b0) begin mismatched++; $display("FAIL reset_gie: got %b expected 0", global_int_en_o); end
    compared++;
    if (mepc_o !== 32'h0) begin mismatched++; $display("FAIL reset_mepc: got %h expected 0", mepc_o); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    ex_wr(32'h305, 32'h8000_0103);
    tick(); idle();
    compared++;
    if (mtvec_o !== 32'h8000_0100) begin mismatched++; $display("FAIL mtvec_out: got %h expected %h", mtvec_o, 32'h8000_0100); end
    rd(32'h305);
    compared++;
    if (csr_rdata_o !== 32'h8000_0100) begin mismatched++; $display("FAIL mtvec_read: got %h expected %h", csr_rdata_o, 32'h8000_0100); end

    ex_wr(32'h300, 32'hFFFF_FFFF);
    tick(); idle();
    rd(32'h300);
    compared++;
    if (csr_rdata_o !== 32'h0000_1888) begin mismatched++; $display("FAIL mstatus_read: got %h expected %h", csr_rdata_o, 32'h1888); end
    compared++;
    if (mstatus_o !== 32'h0000_1888) begin mismatched++; $display("FAIL mstatus_out: got %h expected %h", mstatus_o, 32'h1888); end
    compared++;
    if (global_int_en_o !== 1'b1) begin mismatched++; $display("FAIL gie_set: got %b expected 1", global_int_en_o); end

    ex_wr(32'h304, 32'hDEAD_BEEF);
    clint_wr(32'h340, 32'h1234_5678);
    tick(); idle();
    ex_wr(32'h341, 32'h0000_0107);
    clint_wr(32'h342, 32'h8000_000B);
    tick(); idle();
    rd(32'h304);
    compared++;
    if (csr_rdata_o !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL mie_read: got %h expected %h", csr_rdata_o, 32'hDEADBEEF); end
    rd(32'h340);
    compared++;
    if (csr_rdata_o !== 32'h1234_5678) begin mismatched++; $display("FAIL mscratch_read: got %h expected %h", csr_rdata_o, 32'h12345678); end
    rd(32'h341);
    compared++;
    if (csr_rdata_o !== 32'h0000_0104) begin mismatched++; $display("FAIL mepc_read: got %h expected %h", csr_rdata_o, 32'h104); end
    compared++;
    if (mepc_o !== 32'h0000_0104) begin mismatched++; $display("FAIL mepc_out: got %h expected %h", mepc_o, 32'h104); end
    rd(32'h342);
    compared++;
    if (csr_rdata_o !== 32'h8000_000B) begin mismatched++; $display("FAIL mcause_read: got %h expected %h", csr_rdata_o, 32'h8000000B); end

    clint_wr(32'h300, 32'h0000_0000);
    tick(); idle();
    compared++;
    if (global_int_en_o !== 1'b0) begin mismatched++; $display("FAIL gie_clear: got %b expected 0", global_int_en_o); end
    compared++;
    if (mstatus_o !== 32'h0000_1800) begin mismatched++; $display("FAIL mstatus_clear: got %h expected %h", mstatus_o, 32'h1800); end
  endtask

  task automatic test_collision();
    logic [31:0] exp_byp;
`ifdef CSR_BYPASS_EN
    exp_byp = 32'h0000_0200;
`else
    exp_byp = 32'h0000_0104;
`endif
    ex_wr(32'h341, 32'h0000_0100);
    clint_wr(32'h341, 32'h0000_0200);
    rd(32'h341);
    compared++;
    if (csr_rdata_o !== exp_byp) begin mismatched++; $display("FAIL collide_same_cycle: got %h expected %h", csr_rdata_o, exp_byp); end
    tick(); idle();
    compared++;
    if (mepc_o !== 32'h0000_0200) begin mismatched++; $display("FAIL collide_mepc: got %h expected %h", mepc_o, 32'h200); end
    rd(32'h341);
    compared++;
    if (csr_rdata_o !== 32'h0000_0200) begin mismatched++; $display("FAIL collide_read: got %h expected %h", csr_rdata_o, 32'h200); end
  endtask

  task automatic test_cycle_carry();
    ex_wr(32'hB00, 32'hFFFF_FFFE);
    clint_wr(32'hB80, 32'h0000_0000);
    tick(); idle();
    rd(32'hB00);
    compared++;
    if (csr_rdata_o !== 32'hFFFF_FFFE) begin mismatched++; $display("FAIL mcycle_load: got %h expected %h", csr_rdata_o, 32'hFFFFFFFE); end
    rd(32'hB80);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL mcycleh_load: got %h expected 0", csr_rdata_o); end
    tick();
    rd(32'hB00);
    compared++;
    if (csr_rdata_o !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL mcycle_inc: got %h expected %h", csr_rdata_o, 32'hFFFFFFFF); end
    tick();
    rd(32'hB00);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL mcycle_wrap: got %h expected 0", csr_rdata_o); end
    rd(32'hB80);
    compared++;
    if (csr_rdata_o !== 32'h1) begin mismatched++; $display("FAIL mcycleh_carry: got %h expected 1", csr_rdata_o); end
    rd(32'hC80);
    compared++;
    if (csr_rdata_o !== 32'h1) begin mismatched++; $display("FAIL cycleh_mirror: got %h expected 1", csr_rdata_o); end
    rd(32'hC00);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL cycle_mirror: got %h expected 0", csr_rdata_o); end

    // hi-half write coincident with a lo wrap: hi takes the written value, lo wraps
    ex_wr(32'hB00, 32'hFFFF_FFFF);
    tick(); idle();
    ex_wr(32'hB80, 32'h0000_000A);
    tick(); idle();
    rd(32'hB00);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL hiwr_lo_wrap: got %h expected 0", csr_rdata_o); end
    rd(32'hB80);
    compared++;
    if (csr_rdata_o !== 32'hA) begin mismatched++; $display("FAIL hiwr_hi_value: got %h expected %h", csr_rdata_o, 32'hA); end
  endtask

  task automatic test_instret();
    rd(32'hB02);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL instret_start: got %h expected 0", csr_rdata_o); end
    for (int i = 0; i < 5; i++) begin
      instret_i = 1'b1;
      tick();
      instret_i = 1'b0;
      tick();
    end
    rd(32'hB02);
    compared++;
    if (csr_rdata_o !== 32'h5) begin mismatched++; $display("FAIL minstret_5: got %h expected 5", csr_rdata_o); end
    rd(32'hC02);
    compared++;
    if (csr_rdata_o !== 32'h5) begin mismatched++; $display("FAIL instret_mirror_5: got %h expected 5", csr_rdata_o); end
    rd(32'hB82);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL minstreth_0: got %h expected 0", csr_rdata_o); end

    ex_wr(32'hC02, 32'h0000_0077);
    tick(); idle();
    rd(32'hC02);
    compared++;
    if (csr_rdata_o !== 32'h5) begin mismatched++; $display("FAIL instret_ro: got %h expected 5", csr_rdata_o); end

    ex_wr(32'hB02, 32'h0000_0009);
    instret_i = 1'b1;
    tick(); idle();
    rd(32'hB02);
    compared++;
    if (csr_rdata_o !== 32'h9) begin mismatched++; $display("FAIL minstret_wr_wins: got %h expected 9", csr_rdata_o); end
  endtask

  task automatic test_unmapped();
    rd(32'h0000_07C0);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL unmapped_7c0: got %h expected 0", csr_rdata_o); end
    rd(32'h0000_1300);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL unmapped_1300: got %h expected 0", csr_rdata_o); end
    ex_wr(32'h0000_1300, 32'hFFFF_FFFF);
    clint_wr(32'h0000_07C0, 32'h0000_FFFF);
    tick(); idle();
    compared++;
    if (mstatus_o !== 32'h0000_1800) begin mismatched++; $display("FAIL unmapped_wr_mstatus: got %h expected %h", mstatus_o, 32'h1800); end
    compared++;
    if (global_int_en_o !== 1'b0) begin mismatched++; $display("FAIL unmapped_wr_gie: got %b expected 0", global_int_en_o); end
    rd(32'h304);
    compared++;
    if (csr_rdata_o !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL unmapped_wr_mie: got %h expected %h", csr_rdata_o, 32'hDEADBEEF); end
    rd(32'h0000_1300);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL unmapped_wr_read: got %h expected 0", csr_rdata_o); end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    ex_wr(32'h340, 32'h0000_AAAA);
    clint_wr(32'h305, 32'h0000_0F00);
    tick();
    rst = 1'b0; idle();
    rd(32'h340);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL rstpri_mscratch: got %h expected 0", csr_rdata_o); end
    compared++;
    if (mtvec_o !== 32'h0) begin mismatched++; $display("FAIL rstpri_mtvec: got %h expected 0", mtvec_o); end
    compared++;
    if (mepc_o !== 32'h0) begin mismatched++; $display("FAIL rstpri_mepc: got %h expected 0", mepc_o); end
    rd(32'hB80);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL rstpri_mcycleh: got %h expected 0", csr_rdata_o); end
    rd(32'hB00);
    compared++;
    if (csr_rdata_o !== 32'h0) begin mismatched++; $display("FAIL rstpri_mcycle: got %h expected 0", csr_rdata_o); end
    tick();
    rd(32'hB00);
    compared++;
    if (csr_rdata_o !== 32'h1) begin mismatched++; $display("FAIL post_rst_count: got %h expected 1", csr_rdata_o); end
  endtask

  initial begin
    rst           = 1'b1;
    csr_raddr_i   = 32'h0;
    we_i          = 1'b0;
    waddr_i       = 32'h0;
    wdata_i       = 32'h0;
    clint_we_i    = 1'b0;
    clint_waddr_i = 32'h0;
    clint_wdata_i = 32'h0;
    instret_i     = 1'b0;

    test_reset();
    test_write();
    test_collision();
    test_cycle_carry();
    test_instret();
    test_unmapped();
    test_reset_priority();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
